// File: rtl/checker_rr_scheduler.sv
// Round-robin front end: buffers one source's record, then replays it gap-free to a shared format checker.
// Optional macro STALL_TIMEOUT_EN aborts a record whose owner stalls for TIMEOUT consecutive cycles.
`timescale 1ns/1ps
module checker_rr_scheduler #(
  parameter int N_SRC   = 2,
  parameter int MAX_LEN = 48,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_char,
  output logic [N_SRC-1:0]   src_ready,
  output logic [N_SRC-1:0]   grant,
  output logic [7:0]         chk_char,
  output logic               chk_reset,
  input  logic [1:0]         chk_type,
  output logic               rec_done,
  output logic [1:0]         rec_src,
  output logic [1:0]         rec_type,
  output logic               rec_trunc,
  output logic               rec_abort
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, PLAY, EVAL} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] gidx;
  logic [5:0] len;
  logic [5:0] pidx;
  logic       trunc_flag;
  logic [7:0] rec_buf [MAX_LEN];

  logic             req_found;
  logic [1:0]       req_idx;
  logic [N_SRC-1:0] req_onehot;
  logic [7:0]       cur_char;
  logic             cur_valid;

  // First requesting source at or after rr_ptr, searched cyclically.
  always_comb begin
    req_found  = 1'b0;
    req_idx    = '0;
    req_onehot = '0;
    for (int k = 0; k < N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!req_found && src_valid[i] && (i == (int'(rr_ptr) + k) % N_SRC)) begin
          req_found     = 1'b1;
          req_idx       = 2'(i);
          req_onehot    = '0;
          req_onehot[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur_char  = '0;
    cur_valid = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx == 2'(i)) begin
        cur_char  = src_char[8*i +: 8];
        cur_valid = src_valid[i];
      end
    end
  end

  // src_ready[g] is always high while in LOAD, so valid alone marks a transfer.
  always_ff @(posedge clk) begin
    if (state == LOAD && cur_valid) begin
      rec_buf[len] <= cur_char;
    end
  end

`ifdef STALL_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] stall_cnt;
  logic                         abort_flag;
`else
  // TIMEOUT only matters when the stall timer is built in.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign rec_abort  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      len        <= '0;
      pidx       <= '0;
      trunc_flag <= 1'b0;
      grant      <= '0;
      src_ready  <= '0;
      chk_char   <= 8'h00;
      chk_reset  <= 1'b1;
      rec_done   <= 1'b0;
      rec_src    <= '0;
      rec_type   <= '0;
      rec_trunc  <= 1'b0;
`ifdef STALL_TIMEOUT_EN
      stall_cnt  <= '0;
      abort_flag <= 1'b0;
      rec_abort  <= 1'b0;
`endif
    end else begin
      rec_done <= 1'b0;
      case (state)
        IDLE: begin
          chk_reset <= 1'b0;
          chk_char  <= 8'h00;
          if (req_found) begin
            gidx       <= req_idx;
            grant      <= req_onehot;
            src_ready  <= req_onehot;
            rr_ptr     <= (req_idx == 2'(N_SRC-1)) ? 2'd0 : req_idx + 2'd1;
            len        <= '0;
            trunc_flag <= 1'b0;
`ifdef STALL_TIMEOUT_EN
            stall_cnt  <= '0;
            abort_flag <= 1'b0;
`endif
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (cur_valid) begin
            len <= len + 6'd1;
`ifdef STALL_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (cur_char == 8'h23 || len == 6'(MAX_LEN-1)) begin
              trunc_flag <= (cur_char != 8'h23);
              src_ready  <= '0;
              chk_reset  <= 1'b1;
              chk_char   <= 8'h00;
              state      <= FLUSH;
            end
          end
`ifdef STALL_TIMEOUT_EN
          // Owner went silent too long: drop the record and report it as aborted.
          else if (int'(stall_cnt) == TIMEOUT-1) begin
            abort_flag <= 1'b1;
            src_ready  <= '0;
            state      <= EVAL;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        FLUSH: begin
          chk_reset <= 1'b0;
          chk_char  <= rec_buf[0];
          pidx      <= 6'd1;
          state     <= PLAY;
        end
        PLAY: begin
          if (pidx == len) begin
            chk_char <= 8'h00;
            state    <= EVAL;
          end else begin
            chk_char <= rec_buf[pidx];
            pidx     <= pidx + 6'd1;
          end
        end
        EVAL: begin
          chk_char  <= 8'h00;
          rec_src   <= gidx;
          rec_trunc <= trunc_flag;
          rec_done  <= 1'b1;
          grant     <= '0;
          state     <= IDLE;
`ifdef STALL_TIMEOUT_EN
          rec_type  <= abort_flag ? 2'b00 : chk_type;
          rec_abort <= abort_flag;
`else
          rec_type  <= chk_type;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checker_rr_scheduler.sv
// Scoreboard bench for checker_rr_scheduler with a small stand-in format checker.
// Builds the abort scenario only when STALL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_checker_rr_scheduler;
  localparam int N_SRC   = 2;
  localparam int MAX_LEN = 48;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_SRC-1:0]   src_valid;
  logic [8*N_SRC-1:0] src_char;
  logic [N_SRC-1:0]   src_ready;
  logic [N_SRC-1:0]   grant;
  logic [7:0]         chk_char;
  logic               chk_reset;
  logic [1:0]         chk_type;
  logic               rec_done;
  logic [1:0]         rec_src;
  logic [1:0]         rec_type;
  logic               rec_trunc;
  logic               rec_abort;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  int    q_src[$];
  int    q_type[$];
  int    q_trunc[$];
  int    q_abort[$];
  string q_play[$];
  int    q_len[$];

  int    flush_cnt = 0;
  bit    capturing = 1'b0;
  string play = "";
  int    last_xfer = 0;
  int    e_src, e_type, e_trunc, e_abort, e_len;
  string e_play;

  logic seen_d, seen_s;

  checker_rr_scheduler #(.N_SRC(N_SRC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_char(src_char),
    .src_ready(src_ready), .grant(grant), .chk_char(chk_char), .chk_reset(chk_reset),
    .chk_type(chk_type), .rec_done(rec_done), .rec_src(rec_src), .rec_type(rec_type),
    .rec_trunc(rec_trunc), .rec_abort(rec_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Stand-in checker: '$' before '#' means type 1, '*' before '#' means type 2.
  always @(posedge clk) begin
    if (chk_reset) begin
      seen_d   <= 1'b0;
      seen_s   <= 1'b0;
      chk_type <= 2'b00;
    end else begin
      if (chk_char == 8'h24) seen_d <= 1'b1;
      if (chk_char == 8'h2A) seen_s <= 1'b1;
      if (chk_char == 8'h23) chk_type <= seen_d ? 2'b01 : (seen_s ? 2'b10 : 2'b00);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkStr(input string name, input string actual, input string expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got \"%s\" expected \"%s\"", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int src, input int typ, input int trunc, input int abrt,
                         input string pl, input int len);
    q_src.push_back(src);
    q_type.push_back(typ);
    q_trunc.push_back(trunc);
    q_abort.push_back(abrt);
    q_play.push_back(pl);
    q_len.push_back(len);
  endtask

  task automatic clearExp();
    q_src.delete(); q_type.delete(); q_trunc.delete();
    q_abort.delete(); q_play.delete(); q_len.delete();
  endtask

  // Monitor: reconstructs the replayed stream and checks each finished record.
  always @(negedge clk) begin
    if (!reset) begin
      flush_cnt = 0;
      capturing = 1'b0;
      play = "";
    end else begin
      if (|(src_valid & src_ready)) last_xfer = cyc;
      if (chk_reset && grant != '0) begin
        flush_cnt++;
        capturing = 1'b1;
        play = "";
      end else if (capturing) begin
        if (chk_char != 8'h00) play = $sformatf("%s%c", play, chk_char);
        else capturing = 1'b0;
      end
      if (rec_done) begin
        done_cnt++;
        if (q_src.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rec_done: got rec_done=1 expected 0");
        end else begin
          e_src = q_src.pop_front();
          e_type = q_type.pop_front();
          e_trunc = q_trunc.pop_front();
          e_abort = q_abort.pop_front();
          e_play = q_play.pop_front();
          e_len = q_len.pop_front();
          checkOutput("rec_src", int'(rec_src), e_src);
          checkOutput("rec_type", int'(rec_type), e_type);
          checkOutput("rec_trunc", int'(rec_trunc), e_trunc);
          checkOutput("rec_abort", int'(rec_abort), e_abort);
          checkStr("played_stream", play, e_play);
          checkOutput("flush_cycles", flush_cnt, e_abort ? 0 : 1);
          if (e_len >= 0) checkOutput("latency", cyc - last_xfer, e_len + 3);
        end
        flush_cnt = 0;
        play = "";
      end
    end
  end

  task automatic applyStimulus(input int src, input string str, input int max_gap,
                               input int wait_bound, output int accepted);
    accepted = 0;
    for (int i = 0; i < str.len(); i++) begin
      bit ok;
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      src_char[8*src +: 8] = str[i];
      src_valid[src] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < wait_bound && !ok; t++) begin
        @(negedge clk);
        if (src_ready[src]) ok = 1'b1;
        @(posedge clk);
        #1;
      end
      src_valid[src] = 1'b0;
      if (!ok) break;
      accepted++;
    end
  endtask

  task automatic waitDrain();
    int t = 0;
    while (q_src.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checkOutput("records_pending", q_src.size(), 0);
    clearExp();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string s1, s2, s3a, s3b, s4, s5, s5b;
    int acc, acc_a, acc_b, d0;
    s1  = "^12@00003000: $5<=0000abcd#";
    s2  = "^7@0000300c: *00001000<=00000010#";
    s3a = "^1@0: $1<=2#";
    s3b = "^2@4: *8<=9#";
    s5  = "^3@8: $7<=1#";
    s5b = "^4@c: $2<=3#";
    s4  = "";
    for (int i = 0; i < 60; i++) s4 = $sformatf("%s%c", s4, 8'h61 + (i % 26));

    reset = 1'b0;
    src_valid = '0;
    src_char = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", int'(grant), 0);
    checkOutput("reset_src_ready", int'(src_ready), 0);
    checkOutput("reset_chk_char", int'(chk_char), 0);
    checkOutput("reset_chk_reset", int'(chk_reset), 1);
    checkOutput("reset_rec_done", int'(rec_done), 0);
    checkOutput("reset_rec_type", int'(rec_type), 0);
    checkOutput("reset_rec_abort", int'(rec_abort), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_chk_reset", int'(chk_reset), 0);

    $display("[TB] type-1 record on source 0");
    pushExp(0, 1, 0, 0, s1, s1.len());
    applyStimulus(0, s1, 0, 50, acc);
    checkOutput("t1_accepted", acc, s1.len());
    waitDrain();

    $display("[TB] type-2 record on source 1 with valid gaps");
    pushExp(1, 2, 0, 0, s2, s2.len());
    applyStimulus(1, s2, 3, 50, acc);
    checkOutput("t2_accepted", acc, s2.len());
    waitDrain();

    $display("[TB] simultaneous requests, two rounds");
    for (int r = 0; r < 2; r++) begin
      pushExp(0, 1, 0, 0, s3a, s3a.len());
      pushExp(1, 2, 0, 0, s3b, s3b.len());
      fork
        applyStimulus(0, s3a, 0, 200, acc_a);
        applyStimulus(1, s3b, 0, 200, acc_b);
      join
      checkOutput("t3_accepted_src0", acc_a, s3a.len());
      checkOutput("t3_accepted_src1", acc_b, s3b.len());
      waitDrain();
    end

    $display("[TB] 60-char record without terminator");
    pushExp(0, 0, 1, 0, s4.substr(0, MAX_LEN-1), MAX_LEN);
    applyStimulus(0, s4, 0, 10, acc);
    checkOutput("t4_accepted", acc, MAX_LEN);
    waitDrain();

    $display("[TB] reset during replay");
    pushExp(1, 1, 0, 0, s5, s5.len());
    applyStimulus(1, s5, 0, 50, acc);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t5_chk_reset", int'(chk_reset), 1);
    checkOutput("t5_grant", int'(grant), 0);
    checkOutput("t5_src_ready", int'(src_ready), 0);
    clearExp();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("t5_no_rec_done", done_cnt - d0, 0);
    pushExp(0, 1, 0, 0, s5b, s5b.len());
    applyStimulus(0, s5b, 0, 50, acc);
    checkOutput("t5_after_accepted", acc, s5b.len());
    waitDrain();

`ifdef STALL_TIMEOUT_EN
    $display("[TB] stalled record aborts");
    pushExp(0, 0, 0, 1, "", -1);
    applyStimulus(0, "^12@", 0, 50, acc);
    checkOutput("t6_accepted", acc, 4);
    waitDrain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
